// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if
//   Bundles the client-side request/response buses and the SRAM controller
//   command/return bus of sram_rr_arbiter.
//   slave  : the arbiter's view (accepts client requests, drives SRAM commands).
//   master : the environment's view (clients and SRAM controller).
//   Write requests : w_din_valid / w_din_ready / w_din ({mask,addr,data} per port)
//   Read requests  : r_din_valid / r_din_ready / r_din (address per port)
//   Read responses : r_dout_valid / r_dout_ready / r_dout (show-ahead, per port)
//   SRAM command   : sram_addr_valid / sram_ready / sram_addr / sram_data_in /
//                    sram_write_mask (0 = read)
//   SRAM return    : sram_data_out_valid / sram_data_out (in issue order)
//   rsp_orphan     : sticky flag, return data arrived with nothing outstanding
interface sram_rr_arbiter_if #(
    parameter int NUM_W  = 2,
    parameter int NUM_R  = 2,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic [NUM_W-1:0]                        w_din_valid;
    logic [NUM_W-1:0]                        w_din_ready;
    logic [NUM_W*(MASK_W+ADDR_W+DATA_W)-1:0] w_din;
    logic [NUM_R-1:0]                        r_din_valid;
    logic [NUM_R-1:0]                        r_din_ready;
    logic [NUM_R*ADDR_W-1:0]                 r_din;
    logic [NUM_R-1:0]                        r_dout_valid;
    logic [NUM_R-1:0]                        r_dout_ready;
    logic [NUM_R*DATA_W-1:0]                 r_dout;
    logic                                    sram_addr_valid;
    logic                                    sram_ready;
    logic [ADDR_W-1:0]                       sram_addr;
    logic [DATA_W-1:0]                       sram_data_in;
    logic [MASK_W-1:0]                       sram_write_mask;
    logic [DATA_W-1:0]                       sram_data_out;
    logic                                    sram_data_out_valid;
    logic                                    rsp_orphan;

    modport slave (
        input  w_din_valid, w_din, r_din_valid, r_din, r_dout_ready,
               sram_ready, sram_data_out, sram_data_out_valid,
        output w_din_ready, r_din_ready, r_dout_valid, r_dout,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, rsp_orphan
    );

    modport master (
        output w_din_valid, w_din, r_din_valid, r_din, r_dout_ready,
               sram_ready, sram_data_out, sram_data_out_valid,
        input  w_din_ready, r_din_ready, r_dout_valid, r_dout,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, rsp_orphan
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Round-robin arbiter placing NUM_W write ports and NUM_R read ports onto a
//   single SRAM controller command port. Requesters are numbered 0..NUM_W-1
//   (writes) then NUM_W..NUM_W+NUM_R-1 (reads). A registered command slot
//   honours sram_ready backpressure; outstanding reads are tracked by an
//   in-order tag FIFO and returned through per-port output FIFOs whose space
//   is reserved up front by per-port credits.
//   Ports:
//     sram_clock : sole clock
//     reset      : synchronous, active-high
//     bus        : sram_rr_arbiter_if.slave (client and SRAM controller buses)
module sram_rr_arbiter #(
    parameter int NUM_W     = 2,
    parameter int NUM_R     = 2,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32,
    parameter int MASK_W    = 4,
    parameter int TAG_DEPTH = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic             sram_clock,
    input  logic             reset,
    sram_rr_arbiter_if.slave bus
);
    localparam int NREQ = NUM_W + NUM_R;
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW   = (NUM_R > 1) ? $clog2(NUM_R) : 1;
    localparam int TW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int TCW  = $clog2(TAG_DEPTH + 1);
    localparam int OW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCW  = $clog2(OUT_DEPTH + 1);
    localparam int WREC = MASK_W + ADDR_W + DATA_W;

    // Command register
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [MASK_W-1:0] cmd_mask;
    logic [GW-1:0]     last_grant;

    // Arbitration
    logic [NREQ-1:0]   elig;
    logic              slot_open;
    logic              grant_valid;
    logic [GW-1:0]     grant_idx;
    logic              grant_is_read;
    logic [RW-1:0]     grant_rport;
    logic [NUM_R-1:0]  grant_r;
    logic [WREC-1:0]   grant_wrec;
    logic [ADDR_W-1:0] grant_raddr;

    // Tag FIFO (read port id of each outstanding read, in issue order)
    logic [RW-1:0]     tag_mem [TAG_DEPTH];
    logic [TW-1:0]     tag_wr;
    logic [TW-1:0]     tag_rd;
    logic [TCW-1:0]    tag_count;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_push;
    logic              tag_pop;
    logic [RW-1:0]     tag_head;

    // Per-read-port output FIFOs and credits
    logic [DATA_W-1:0] out_mem [NUM_R][OUT_DEPTH];
    logic [OW-1:0]     out_wr  [NUM_R];
    logic [OW-1:0]     out_rd  [NUM_R];
    logic [OCW-1:0]    out_cnt [NUM_R];
    logic [OCW-1:0]    credit  [NUM_R];
    logic [NUM_R-1:0]  out_push;
    logic [NUM_R-1:0]  out_pop;

    logic              orphan;

    assign tag_full  = (tag_count == TCW'(TAG_DEPTH));
    assign tag_empty = (tag_count == '0);
    assign tag_head  = tag_mem[tag_rd];
    assign tag_push  = grant_is_read;
    assign tag_pop   = bus.sram_data_out_valid && !tag_empty;

    // The slot is free if empty, or if its current command leaves this cycle.
    assign slot_open = !cmd_valid || bus.sram_ready;

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path through the block can leave it holding state (no latch).
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_W; i++) begin
            elig[i] = bus.w_din_valid[i];
        end
        for (int j = 0; j < NUM_R; j++) begin
            elig[NUM_W+j] = bus.r_din_valid[j] && (credit[j] != '0) && !tag_full;
        end
    end

    // Rotating priority: offset k=1 is the requester right after last_grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (slot_open && !reset) begin
            for (int k = 1; k <= NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!grant_valid && elig[i] && (((int'(last_grant) + k) % NREQ) == i)) begin
                        grant_valid = 1'b1;
                        grant_idx   = GW'(i);
                    end
                end
            end
        end
    end

    // Grant decode: one-hot ready back to the winner and its payload.
    always_comb begin
        bus.w_din_ready = '0;
        bus.r_din_ready = '0;
        grant_r         = '0;
        grant_is_read   = 1'b0;
        grant_rport     = '0;
        grant_wrec      = '0;
        grant_raddr     = '0;
        for (int i = 0; i < NUM_W; i++) begin
            if (grant_valid && (grant_idx == GW'(i))) begin
                bus.w_din_ready[i] = 1'b1;
                grant_wrec         = bus.w_din[i*WREC +: WREC];
            end
        end
        for (int j = 0; j < NUM_R; j++) begin
            if (grant_valid && (grant_idx == GW'(NUM_W + j))) begin
                bus.r_din_ready[j] = 1'b1;
                grant_r[j]         = 1'b1;
                grant_is_read      = 1'b1;
                grant_rport        = RW'(j);
                grant_raddr        = bus.r_din[j*ADDR_W +: ADDR_W];
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs as they stood before the clock edge.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            cmd_valid  <= 1'b0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
            cmd_mask   <= '0;
            last_grant <= GW'(NREQ - 1);
        end else if (grant_valid) begin
            // A grant only happens into an open slot, so overwriting is safe.
            cmd_valid  <= 1'b1;
            last_grant <= grant_idx;
            if (grant_is_read) begin
                cmd_addr <= grant_raddr;
                cmd_data <= '0;
                cmd_mask <= '0;
            end else begin
                {cmd_mask, cmd_addr, cmd_data} <= grant_wrec;
            end
        end else if (bus.sram_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    assign bus.sram_addr_valid = cmd_valid;
    assign bus.sram_addr       = cmd_addr;
    assign bus.sram_data_in    = cmd_data;
    assign bus.sram_write_mask = cmd_mask;

    // NOTE: storage arrays carry no reset; the pointers and counts that guard
    // them are reset, so stale contents are never observed.
    always_ff @(posedge sram_clock) begin
        if (tag_push) begin
            tag_mem[tag_wr] <= grant_rport;
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            tag_wr    <= '0;
            tag_rd    <= '0;
            tag_count <= '0;
            orphan    <= 1'b0;
        end else begin
            if (tag_push) begin
                tag_wr <= (tag_wr == TW'(TAG_DEPTH - 1)) ? '0 : tag_wr + TW'(1);
            end
            if (tag_pop) begin
                tag_rd <= (tag_rd == TW'(TAG_DEPTH - 1)) ? '0 : tag_rd + TW'(1);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + TCW'(1);
                2'b01:   tag_count <= tag_count - TCW'(1);
                default: tag_count <= tag_count;
            endcase
            // Return data with nothing outstanding is dropped and flagged.
            if (bus.sram_data_out_valid && tag_empty) begin
                orphan <= 1'b1;
            end
        end
    end

    assign bus.rsp_orphan = orphan;

    always_comb begin
        out_push = '0;
        out_pop  = '0;
        for (int j = 0; j < NUM_R; j++) begin
            out_push[j] = tag_pop && (tag_head == RW'(j));
            out_pop[j]  = (out_cnt[j] != '0) && bus.r_dout_ready[j];
        end
    end

    always_ff @(posedge sram_clock) begin
        for (int j = 0; j < NUM_R; j++) begin
            if (out_push[j]) begin
                out_mem[j][out_wr[j]] <= bus.sram_data_out;
            end
        end
    end

    // Credits reserve output FIFO space at issue time, so a return can never
    // find its FIFO full.
    always_ff @(posedge sram_clock) begin
        for (int j = 0; j < NUM_R; j++) begin
            if (reset) begin
                out_wr[j]  <= '0;
                out_rd[j]  <= '0;
                out_cnt[j] <= '0;
                credit[j]  <= OCW'(OUT_DEPTH);
            end else begin
                if (out_push[j]) begin
                    out_wr[j] <= (out_wr[j] == OW'(OUT_DEPTH - 1)) ? '0 : out_wr[j] + OW'(1);
                end
                if (out_pop[j]) begin
                    out_rd[j] <= (out_rd[j] == OW'(OUT_DEPTH - 1)) ? '0 : out_rd[j] + OW'(1);
                end
                case ({out_push[j], out_pop[j]})
                    2'b10:   out_cnt[j] <= out_cnt[j] + OCW'(1);
                    2'b01:   out_cnt[j] <= out_cnt[j] - OCW'(1);
                    default: out_cnt[j] <= out_cnt[j];
                endcase
                case ({grant_r[j], out_pop[j]})
                    2'b10:   credit[j] <= credit[j] - OCW'(1);
                    2'b01:   credit[j] <= credit[j] + OCW'(1);
                    default: credit[j] <= credit[j];
                endcase
            end
        end
    end

    // Show-ahead outputs: head word is visible whenever the FIFO is non-empty.
    always_comb begin
        bus.r_dout_valid = '0;
        bus.r_dout       = '0;
        for (int j = 0; j < NUM_R; j++) begin
            bus.r_dout_valid[j]            = (out_cnt[j] != '0);
            bus.r_dout[j*DATA_W +: DATA_W] = out_mem[j][out_rd[j]];
        end
    end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter
//   Directed bench for sram_rr_arbiter with default parameters. Inputs change
//   1 time unit after the rising edge, outputs are sampled on the falling
//   edge. A small SRAM model returns read data two cycles after a read command
//   is accepted, or the test drives returns by hand.
module tb_sram_rr_arbiter;
    localparam int NUM_W     = 2;
    localparam int NUM_R     = 2;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 32;
    localparam int MASK_W    = 4;
    localparam int TAG_DEPTH = 8;
    localparam int OUT_DEPTH = 4;
    localparam int WREC      = MASK_W + ADDR_W + DATA_W;

    typedef struct {
        logic [NUM_W-1:0] w_valid;
        logic [NUM_R-1:0] r_valid;
        logic             sram_ready;
        logic [NUM_W-1:0] exp_w_ready;
        logic [NUM_R-1:0] exp_r_ready;
    } vec_t;

    logic sram_clock = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM model state
    logic              sram_auto;
    logic              man_valid;
    logic [DATA_W-1:0] man_data;
    logic              acc;
    logic [ADDR_W-1:0] acc_addr;
    logic              v1, v2;
    logic [ADDR_W-1:0] a1, a2;

    always #5 sram_clock = ~sram_clock;

    sram_rr_arbiter_if #(
        .NUM_W(NUM_W), .NUM_R(NUM_R), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)
    ) bus ();

    sram_rr_arbiter #(
        .NUM_W(NUM_W), .NUM_R(NUM_R), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .TAG_DEPTH(TAG_DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .sram_clock(sram_clock),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        return (a == 18'h00020) ? 32'h12345678 : {14'h2A5, a};
    endfunction

    // SRAM model: a read accepted in cycle c returns in cycle c+2.
    initial begin
        v1 = 1'b0; v2 = 1'b0; a1 = '0; a2 = '0;
        bus.sram_data_out_valid = 1'b0;
        bus.sram_data_out       = '0;
        forever begin
            @(negedge sram_clock);
            acc      = bus.sram_addr_valid && bus.sram_ready && (bus.sram_write_mask == '0);
            acc_addr = bus.sram_addr;
            @(posedge sram_clock);
            #2;
            if (sram_auto) begin
                v2 = v1; a2 = a1;
                v1 = acc; a1 = acc_addr;
                bus.sram_data_out_valid = v2;
                bus.sram_data_out       = sram_word(a2);
            end else begin
                v1 = 1'b0; v2 = 1'b0;
                bus.sram_data_out_valid = man_valid;
                bus.sram_data_out       = man_data;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic sample();
        @(negedge sram_clock);
    endtask

    task automatic next_cycle();
        @(posedge sram_clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.w_din_valid  = '0;
        bus.w_din        = '0;
        bus.r_din_valid  = '0;
        bus.r_din        = '0;
        bus.r_dout_ready = '0;
        bus.sram_ready   = 1'b0;
        man_valid        = 1'b0;
        man_data         = '0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (3) next_cycle();
        sample();
        check({tag, ".rst_addr_valid"}, 64'(bus.sram_addr_valid), 64'h0);
        check({tag, ".rst_ready"}, 64'({bus.r_din_ready, bus.w_din_ready}), 64'h0);
        check({tag, ".rst_dout_valid"}, 64'(bus.r_dout_valid), 64'h0);
        check({tag, ".rst_orphan"}, 64'(bus.rsp_orphan), 64'h0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [14];
        int   cnt [4];
        int   g;

        // Cycle-by-cycle grant sequence after reset (last_grant = 3).
        vecs[0]  = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b00};  // W0 first
        vecs[1]  = '{2'b11, 2'b11, 1'b1, 2'b10, 2'b00};  // W1
        vecs[2]  = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b01};  // R0
        vecs[3]  = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b10};  // R1
        vecs[4]  = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b00};  // wrap to W0
        vecs[5]  = '{2'b00, 2'b10, 1'b1, 2'b00, 2'b10};  // single requester R1
        vecs[6]  = '{2'b00, 2'b10, 1'b1, 2'b00, 2'b10};
        vecs[7]  = '{2'b00, 2'b10, 1'b1, 2'b00, 2'b10};
        vecs[8]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00};  // idle, slot drains
        vecs[9]  = '{2'b10, 2'b01, 1'b0, 2'b10, 2'b00};  // empty slot opens without ready
        vecs[10] = '{2'b10, 2'b01, 1'b0, 2'b00, 2'b00};  // held command blocks grants
        vecs[11] = '{2'b10, 2'b01, 1'b1, 2'b00, 2'b01};  // draining slot, R0 after W1
        vecs[12] = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b10};  // R1
        vecs[13] = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b00};  // W0

        // Reset with every request asserted: no ready may leak.
        idle_inputs();
        sram_auto        = 1'b1;
        bus.w_din_valid  = '1;
        bus.r_din_valid  = '1;
        do_reset("init");

        // Table-driven grant sequence
        bus.r_dout_ready       = 2'b11;
        bus.w_din[0 +: WREC]    = {4'hF, 18'h00100, 32'hA0A0A0A0};
        bus.w_din[WREC +: WREC] = {4'h3, 18'h00101, 32'hB1B1B1B1};
        bus.r_din               = {18'h00201, 18'h00200};
        for (int i = 0; i < 14; i++) begin
            bus.w_din_valid = vecs[i].w_valid;
            bus.r_din_valid = vecs[i].r_valid;
            bus.sram_ready  = vecs[i].sram_ready;
            sample();
            check($sformatf("table[%0d].w_ready", i), 64'(bus.w_din_ready), 64'(vecs[i].exp_w_ready));
            check($sformatf("table[%0d].r_ready", i), 64'(bus.r_din_ready), 64'(vecs[i].exp_r_ready));
            next_cycle();
        end
        bus.w_din_valid = '0;
        bus.r_din_valid = '0;
        repeat (6) next_cycle();
        sample();
        check("table.orphan", 64'(bus.rsp_orphan), 64'h0);
        next_cycle();

        // Fairness: 100 grants with all four ports requesting.
        idle_inputs();
        do_reset("fair");
        bus.sram_ready   = 1'b1;
        bus.r_dout_ready = 2'b11;
        bus.w_din_valid  = '1;
        bus.r_din_valid  = '1;
        bus.w_din        = {{4'h1, 18'h00011, 32'h1}, {4'h2, 18'h00012, 32'h2}};
        bus.r_din        = {18'h00031, 18'h00030};
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        for (int n = 0; n < 100; n++) begin
            logic [3:0] got;
            sample();
            got = {bus.r_din_ready, bus.w_din_ready};
            check($sformatf("fair[%0d].grant", n), 64'(got), 64'(4'b0001 << (n % 4)));
            for (int p = 0; p < 4; p++) if (got[p]) cnt[p]++;
            next_cycle();
        end
        for (int p = 0; p < 4; p++) check($sformatf("fair.count[%0d]", p), 64'(cnt[p]), 64'd25);

        // Backpressure: W0 command held while sram_ready is low.
        idle_inputs();
        do_reset("stall");
        bus.w_din[0 +: WREC]    = {4'hF, 18'h00010, 32'hDEADBEEF};
        bus.w_din[WREC +: WREC] = {4'h1, 18'h00011, 32'h11111111};
        bus.w_din_valid         = 2'b01;
        sample();
        check("stall.handshake", 64'(bus.w_din_ready), 64'(2'b01));
        check("stall.cmd_empty", 64'(bus.sram_addr_valid), 64'h0);
        next_cycle();
        bus.w_din_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            bus.sram_ready = (c == 3);
            sample();
            check($sformatf("stall[%0d].valid", c), 64'(bus.sram_addr_valid), 64'h1);
            check($sformatf("stall[%0d].cmd", c),
                  64'({bus.sram_write_mask, bus.sram_addr, bus.sram_data_in}),
                  64'({4'hF, 18'h00010, 32'hDEADBEEF}));
            check($sformatf("stall[%0d].ready", c), 64'(bus.w_din_ready), 64'((c == 3) ? 2'b10 : 2'b00));
            next_cycle();
        end
        bus.w_din_valid = '0;
        bus.sram_ready  = 1'b0;
        sample();
        check("stall.next_cmd", 64'({bus.sram_addr_valid, bus.sram_addr}), 64'({1'b1, 18'h00011}));
        next_cycle();

        // Read latency: R1 handshake to r_dout_valid[1] in 4 cycles.
        idle_inputs();
        do_reset("lat");
        bus.sram_ready   = 1'b1;
        bus.r_dout_ready = 2'b11;
        bus.r_din        = {18'h00020, 18'h00000};
        bus.r_din_valid  = 2'b10;
        sample();
        check("lat.handshake", 64'(bus.r_din_ready), 64'(2'b10));
        next_cycle();
        bus.r_din_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            check($sformatf("lat[%0d].dout_valid", c), 64'(bus.r_dout_valid), 64'((c == 4) ? 2'b10 : 2'b00));
            if (c == 4) check("lat.data", 64'(bus.r_dout[DATA_W +: DATA_W]), 64'h12345678);
            next_cycle();
        end
        sample();
        check("lat.popped", 64'(bus.r_dout_valid), 64'h0);
        next_cycle();

        // Credits: R0 stalls at OUT_DEPTH undrained reads, R1 keeps flowing.
        idle_inputs();
        do_reset("credit");
        bus.sram_ready  = 1'b1;
        bus.r_din       = {18'h00301, 18'h00300};
        bus.r_din_valid = 2'b01;
        g = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (bus.r_din_ready[0]) g++;
            next_cycle();
        end
        check("credit.r0_grants", 64'(g), 64'd4);
        bus.r_din_valid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            sample();
            check($sformatf("credit.skip[%0d]", c), 64'(bus.r_din_ready), 64'(2'b10));
            next_cycle();
        end
        bus.r_din_valid = 2'b01;
        g = 0;
        for (int c = 0; c < 4; c++) begin
            bus.r_dout_ready = (c == 0) ? 2'b01 : 2'b00;
            sample();
            if (c == 0) begin
                check("credit.head_valid", 64'(bus.r_dout_valid[0]), 64'h1);
                check("credit.head_data", 64'(bus.r_dout[0 +: DATA_W]), 64'(sram_word(18'h00300)));
            end
            if (bus.r_din_ready[0]) g++;
            next_cycle();
        end
        check("credit.one_more", 64'(g), 64'd1);

        // Tag FIFO full: returns withheld, writes still pass.
        idle_inputs();
        sram_auto = 1'b0;
        do_reset("tag");
        bus.sram_ready       = 1'b1;
        bus.r_dout_ready     = 2'b11;
        bus.r_din            = {18'h00401, 18'h00400};
        bus.w_din[0 +: WREC] = {4'hF, 18'h00050, 32'h55555555};
        bus.r_din_valid      = 2'b11;
        for (int c = 0; c < 8; c++) begin
            sample();
            check($sformatf("tag.issue[%0d]", c), 64'(bus.r_din_ready), 64'(((c % 2) == 0) ? 2'b01 : 2'b10));
            next_cycle();
        end
        bus.w_din_valid = 2'b01;
        sample();
        check("tag.full_write", 64'({bus.r_din_ready, bus.w_din_ready}), 64'({2'b00, 2'b01}));
        next_cycle();
        bus.w_din_valid = '0;
        sample();
        check("tag.full_blocked", 64'(bus.r_din_ready), 64'h0);
        next_cycle();
        man_valid = 1'b1;
        man_data  = 32'hCAFEF00D;
        sample();
        check("tag.return_cycle", 64'(bus.r_din_ready), 64'h0);
        next_cycle();
        man_valid = 1'b0;
        sample();
        check("tag.ret_valid", 64'(bus.r_dout_valid), 64'(2'b01));
        check("tag.ret_data", 64'(bus.r_dout[0 +: DATA_W]), 64'hCAFEF00D);
        check("tag.pop_cycle", 64'(bus.r_din_ready), 64'h0);
        next_cycle();
        sample();
        check("tag.freed", 64'(bus.r_din_ready), 64'(2'b01));
        next_cycle();
        sample();
        check("tag.full_again", 64'(bus.r_din_ready), 64'h0);
        next_cycle();

        // Orphan return after a mid-operation reset (8 tags dropped).
        idle_inputs();
        do_reset("orphan");
        man_valid = 1'b1;
        man_data  = 32'h0BADF00D;
        sample();
        check("orphan.before", 64'(bus.rsp_orphan), 64'h0);
        next_cycle();
        man_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("orphan[%0d].flag", c), 64'(bus.rsp_orphan), 64'h1);
            check($sformatf("orphan[%0d].dout_valid", c), 64'(bus.r_dout_valid), 64'h0);
            next_cycle();
        end
        do_reset("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Single-clock, parametrised N-write / M-read SRAM port arbiter with true round-robin fairness.
- Sits between pipeline client ports (image readers/writers, feature detector) and the SRAM controller on sram_clock.
- Honours sram_ready backpressure, tracks outstanding reads with an in-order tag FIFO, and returns data per read port through credit-managed output FIFOs.
- Clients on other clock domains attach through external async FIFOs.

Parameters:
- NUM_W, 2, number of write ports (>=1)
- NUM_R, 2, number of read ports (>=1)
- ADDR_W, 18, SRAM word address width
- DATA_W, 32, SRAM data width
- MASK_W, 4, byte write-mask width (DATA_W/8)
- TAG_DEPTH, 8, max outstanding reads (power of 2)
- OUT_DEPTH, 4, per-read-port output FIFO depth (power of 2)

Ports:
- sram_clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- w_din_valid  in  NUM_W  write request valid per port
- w_din_ready  out  NUM_W  write request accepted this cycle
- w_din  in  NUM_W*(MASK_W+ADDR_W+DATA_W)  per port {mask,addr,data}; port i at slice i
- r_din_valid  in  NUM_R  read request valid
- r_din_ready  out  NUM_R  read request accepted
- r_din  in  NUM_R*ADDR_W  read addresses
- r_dout_valid  out  NUM_R  read data available (show-ahead)
- r_dout_ready  in  NUM_R  consumer pops head
- r_dout  out  NUM_R*DATA_W  read data per port
- sram_addr_valid  out  1  command valid
- sram_ready  in  1  controller accepts command
- sram_addr  out  ADDR_W  command address
- sram_data_in  out  DATA_W  write data
- sram_write_mask  out  MASK_W  byte mask; 0 = read
- sram_data_out  in  DATA_W  returned read data
- sram_data_out_valid  in  1  returned data valid (in issue order)
- rsp_orphan  out  1  sticky: data returned with tag FIFO empty

Behaviour:
- Requesters are indexed 0..NUM_W-1 for writes, NUM_W..NUM_W+NUM_R-1 for reads.
- Eligibility:
  - Write port i: w_din_valid[i].
  - Read port j: r_din_valid[j] AND credit[j]>0 AND tag FIFO not full.
  - A write with mask 0 is treated as a no-op write and issued unchanged.
- Issue slot: open when !sram_addr_valid OR sram_ready (command register empty or draining this cycle).
- Grant:
  - When the slot is open, combinationally grant the first eligible requester searching from last_grant+1, wrapping modulo NUM_W+NUM_R.
  - Assert exactly that port's din_ready in the same cycle. All other ready signals are 0.
  - last_grant updates only on a grant.
- Command register:
  - Loaded on a grant, so the command appears on sram_* 1 cycle after the handshake.
  - Read command: mask 0, sram_data_in = 0.
  - Held stable while sram_addr_valid && !sram_ready.
  - sram_addr_valid clears when accepted with no new grant.
- Read issue: on a read grant, push port id onto the tag FIFO and decrement credit[j].
- Read return:
  - On sram_data_out_valid, pop the tag FIFO and write sram_data_out into output FIFO[tag].
  - Credits guarantee that FIFO is not full.
  - If the tag FIFO is empty: drop the data and set rsp_orphan.
- Output FIFOs:
  - r_dout_valid[j] = !empty.
  - Pop on r_dout_valid[j] && r_dout_ready[j], which increments credit[j].
  - Same-cycle pop and push on the same FIFO is legal.
  - Same-cycle grant (decrement) and pop (increment) on the same port leaves credit unchanged.
- Credit invariant: credit[j] + outstanding[j] + occupancy[j] == OUT_DEPTH at all times. Credit range is 0..OUT_DEPTH.
- Throughput:
  - 1 command per cycle while sram_ready is held high.
  - Read latency (r_din handshake to r_dout_valid) = 1 + SRAM latency + 1 cycles.
- Boundary conditions:
  - Tag FIFO full: reads ineligible, writes still granted.
  - Credit 0: that read port is skipped; its pending request does not block others.
  - Single requester: granted every open slot.
- Reset:
  - sram_addr_valid=0, all din_ready=0, r_dout_valid=0, rsp_orphan=0.
  - FIFOs emptied, credits=OUT_DEPTH.
  - last_grant = NUM_W+NUM_R-1, so requester 0 has first priority.
- Reset mid-operation: drops the pending command and all in-flight tags. The integrator must quiesce the SRAM controller. Late returns set rsp_orphan.

Test Plan:
- All 4 ports valid continuously, sram_ready=1, after reset → grant order W0,W1,R0,R1,W0,… Each port gets exactly 25 of 100 grants.
- W0 writes {mask=4'hF,addr=18'h00010,data=32'hDEADBEEF} while sram_ready=0 for 3 cycles → sram_* held stable for 4 cycles, w_din_ready[0] pulses once, no further grant until accepted.
- R1 reads addr 18'h00020, SRAM returns 32'h12345678 after 2 cycles, r_dout_ready[1]=1 → r_dout_valid[1] high 4 cycles after the handshake with r_dout slice 1 = 32'h12345678. r_dout_valid[0] stays 0.
- r_dout_ready[0]=0, R0 issues 6 reads with OUT_DEPTH=4 → exactly 4 granted, then R0 skipped while R1 is still granted. Popping one R0 word allows exactly one more R0 grant.
- SRAM withholds returns while 9 reads are requested (TAG_DEPTH=8) → 8 reads issued, reads blocked, W0 write still issued. The first return frees one read slot.
- sram_data_out_valid pulsed with no outstanding reads → data dropped, rsp_orphan=1 until reset, r_dout_valid all 0.
